btb_update_array: RTL and testbench

Two-way, 16-set branch target buffer in the fetch stage. Fetch-side lookups are combinational and return hit plus predicted target. Updates arrive from the branch-resolution target holder over a valid/ready handshake. Each accepted update runs a two-step probe/write sequence with per-set LRU replacement. The holder clears its entry on the handshake cycle.

---
 rtl/btb_update_array.sv | 138 +++++++++++++
 tb/tb_btb_update_array.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_update_array.sv
// btb_update_array: 2-way, 16-set branch target buffer with per-set LRU replacement.
// Lookup is combinational: fetch_pc -> hit / predicted_target. Updates take a valid/ready
// handshake and then run PROBE then WRITE (upd_ready low for two cycles, one update per 3 cycles).
// Ports: clk, rst_n (async active-low); fetch_pc, lookup_valid -> hit, predicted_target;
//        upd_valid/upd_ready with upd_tag, upd_set, upd_target; flush (sync invalidate-all); busy.
module btb_update_array #(
   parameter int TAG_W  = 10,
   parameter int SET_W  = 4,
   parameter int WORD_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WORD_W-1:0] fetch_pc,
   input  logic              lookup_valid,
   output logic              hit,
   output logic [WORD_W-1:0] predicted_target,
   input  logic              upd_valid,
   output logic              upd_ready,
   input  logic [TAG_W-1:0]  upd_tag,
   input  logic [SET_W-1:0]  upd_set,
   input  logic [WORD_W-1:0] upd_target,
   input  logic              flush,
   output logic              busy
);

   localparam int SETS = 1 << SET_W;

   typedef enum logic [1:0] {IDLE, PROBE, WRITE} state_t;

   state_t             state;

   // Way-indexed storage. Only valid and lru need reset; tag/target are
   // meaningless while the matching valid bit is clear.
   logic [SETS-1:0]    valid [2];
   logic [SETS-1:0]    lru;                  // way to replace next
   logic [TAG_W-1:0]   tag_mem [2][SETS];
   logic [WORD_W-1:0]  tgt_mem [2][SETS];

   // Captured update and the victim chosen in PROBE
   logic [TAG_W-1:0]   cap_tag;
   logic [SET_W-1:0]   cap_set;
   logic [WORD_W-1:0]  cap_target;
   logic               victim;

   // ---------------- Lookup ----------------
   logic [SET_W-1:0]   f_set;
   logic [TAG_W-1:0]   f_tag;
   logic               f_hit0;
   logic               f_hit1;
   logic               unused_pc_bits;

   assign f_set = fetch_pc[SET_W:1];
   assign f_tag = fetch_pc[SET_W+TAG_W:SET_W+1];
   // Bit 0 is instruction alignment, the top bit is dropped (aliasing is accepted)
   assign unused_pc_bits = ^{fetch_pc[WORD_W-1:SET_W+TAG_W+1], fetch_pc[0]};

   assign f_hit0 = valid[0][f_set] && (tag_mem[0][f_set] == f_tag);
   assign f_hit1 = valid[1][f_set] && (tag_mem[1][f_set] == f_tag);
   assign hit    = f_hit0 || f_hit1;

   // Way 0 wins when both ways carry the same tag
   assign predicted_target = f_hit0 ? tgt_mem[0][f_set] :
                             f_hit1 ? tgt_mem[1][f_set] : '0;

   // ---------------- Probe / victim select ----------------
   logic               p_match0;
   logic               p_match1;
   logic               p_victim;

   assign p_match0 = valid[0][cap_set] && (tag_mem[0][cap_set] == cap_tag);
   assign p_match1 = valid[1][cap_set] && (tag_mem[1][cap_set] == cap_tag);

   always_comb begin
      p_victim = lru[cap_set];
      if (p_match0)                p_victim = 1'b0;
      else if (p_match1)           p_victim = 1'b1;
      else if (!valid[0][cap_set]) p_victim = 1'b0;
      else if (!valid[1][cap_set]) p_victim = 1'b1;
   end

   assign upd_ready = (state == IDLE) && !flush;
   assign busy      = (state != IDLE);

   // ---------------- Control, valid and LRU ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cap_tag    <= '0;
         cap_set    <= '0;
         cap_target <= '0;
         victim     <= 1'b0;
         valid[0]   <= '0;
         valid[1]   <= '0;
         lru        <= '0;
      end else if (flush) begin
         // Drops any in-flight update; no transfer can happen this cycle
         state    <= IDLE;
         valid[0] <= '0;
         valid[1] <= '0;
         lru      <= '0;
      end else begin
         // Touch first so a same-set WRITE below overrides it.
         // Non-hitting way: 1 if way 0 hit (way 0 wins ties), else 0.
         if (lookup_valid && hit) begin
            lru[f_set] <= f_hit0;
         end
         case (state)
            IDLE: begin
               if (upd_valid) begin
                  cap_tag    <= upd_tag;
                  cap_set    <= upd_set;
                  cap_target <= upd_target;
                  state      <= PROBE;
               end
            end
            PROBE: begin
               victim <= p_victim;
               state  <= WRITE;
            end
            WRITE: begin
               valid[victim][cap_set] <= 1'b1;
               lru[cap_set]           <= ~victim;
               state                  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Tag/target payload; a tag match rewrites the same tag, so only the target changes
   always_ff @(posedge clk) begin
      if (state == WRITE && !flush) begin
         tag_mem[victim][cap_set] <= cap_tag;
         tgt_mem[victim][cap_set] <= cap_target;
      end
   end

endmodule

// File: tb/tb_btb_update_array.sv
// tb_btb_update_array: directed scenarios plus randomized lookups/updates for btb_update_array,
// checked against an array-based BTB model (lookup, LRU touch, replacement by victim priority).
// Ports of the DUT are all driven/observed here; clock period 10 ns.
module tb_btb_update_array;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] fetch_pc = '0;
   logic        lookup_valid = 1'b0;
   logic        hit;
   logic [15:0] predicted_target;
   logic        upd_valid = 1'b0;
   logic        upd_ready;
   logic [9:0]  upd_tag = '0;
   logic [3:0]  upd_set = '0;
   logic [15:0] upd_target = '0;
   logic        flush = 1'b0;
   logic        busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   btb_update_array #(.TAG_W(10), .SET_W(4), .WORD_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc), .lookup_valid(lookup_valid),
      .hit(hit), .predicted_target(predicted_target), .upd_valid(upd_valid),
      .upd_ready(upd_ready), .upd_tag(upd_tag), .upd_set(upd_set),
      .upd_target(upd_target), .flush(flush), .busy(busy)
   );

   // ---------------- Reference model ----------------
   bit          m_valid [16][2];
   logic [9:0]  m_tag   [16][2];
   logic [15:0] m_tgt   [16][2];
   bit          m_lru   [16];

   function automatic void model_clear();
      for (int s = 0; s < 16; s++) begin
         m_valid[s][0] = 0;
         m_valid[s][1] = 0;
         m_lru[s]      = 0;
      end
   endfunction

   function automatic logic [15:0] make_pc(input logic [9:0] t, input logic [3:0] s,
                                           input logic b15, input logic b0);
      return {b15, t, s, b0};
   endfunction

   function automatic void model_lookup(input logic [15:0] pc, output bit h,
                                        output logic [15:0] tg, output int w);
      int s;
      s  = int'(pc[4:1]);
      h  = 0;
      tg = 16'h0000;
      w  = 0;
      // Scan way 1 then way 0 so way 0 has the final say
      for (int i = 1; i >= 0; i--) begin
         if (m_valid[s][i] && m_tag[s][i] == pc[14:5]) begin
            h = 1; tg = m_tgt[s][i]; w = i;
         end
      end
   endfunction

   function automatic void model_touch(input logic [15:0] pc);
      bit h; logic [15:0] tg; int w;
      model_lookup(pc, h, tg, w);
      if (h) m_lru[int'(pc[4:1])] = (w == 0);
   endfunction

   function automatic void model_write(input logic [9:0] t, input logic [3:0] s_in,
                                       input logic [15:0] g);
      int s, w;
      s = int'(s_in);
      if (m_valid[s][0] && m_tag[s][0] == t)      w = 0;
      else if (m_valid[s][1] && m_tag[s][1] == t) w = 1;
      else if (!m_valid[s][0])                    w = 0;
      else if (!m_valid[s][1])                    w = 1;
      else                                        w = m_lru[s] ? 1 : 0;
      m_valid[s][w] = 1;
      m_tag[s][w]   = t;
      m_tgt[s][w]   = g;
      m_lru[s]      = (w == 0);
   endfunction

   // ---------------- Stimulus utilities ----------------
   task automatic wait_edge();
      @(posedge clk);
      #1;
   endtask

   // Full update from an idle array: transfer, PROBE, WRITE; returns one cycle after the write
   task automatic do_update(input logic [9:0] t, input logic [3:0] s, input logic [15:0] g);
      int n = 0;
      while (!upd_ready && n < 8) begin
         wait_edge();
         n++;
      end
      checks++;
      if (upd_ready !== 1'b1) begin
         errors++;
         $display("FAIL update_ready_timeout: upd_ready=%b required 1", upd_ready);
      end
      upd_tag = t; upd_set = s; upd_target = g; upd_valid = 1'b1;
      wait_edge();
      upd_valid = 1'b0;
      wait_edge();
      wait_edge();
      model_write(t, s, g);
   endtask

   // ---------------- Scenarios ----------------
   task automatic test_reset();
      model_clear();
      upd_valid = 1'b1; upd_tag = 10'h3FF; upd_set = 4'h1; upd_target = 16'hDEAD;
      #12;
      checks++;
      if (busy !== 1'b0 || upd_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_outputs: busy=%b upd_ready=%b required busy=0 upd_ready=1", busy, upd_ready);
      end
      #11;                       // t=23: release away from an edge
      upd_valid = 1'b0;
      rst_n = 1'b1;
      wait_edge();
      fetch_pc = 16'h1234;
      #1;
      checks++;
      if (hit !== 1'b0 || predicted_target !== 16'h0000 || upd_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_lookup: hit=%b tgt=%h ready=%b busy=%b required 0 0000 1 0",
                  hit, predicted_target, upd_ready, busy);
      end
   endtask

   task automatic test_basic_update();
      fetch_pc = make_pc(10'h091, 4'hA, 1'b0, 1'b0);
      upd_tag = 10'h091; upd_set = 4'hA; upd_target = 16'h2000; upd_valid = 1'b1;
      wait_edge();               // transfer edge N
      upd_valid = 1'b0;
      #1;
      checks++;
      if (upd_ready !== 1'b0 || busy !== 1'b1 || hit !== 1'b0) begin
         errors++;
         $display("FAIL basic_probe: ready=%b busy=%b hit=%b required 0 1 0", upd_ready, busy, hit);
      end
      wait_edge();               // WRITE cycle: pre-write contents
      checks++;
      if (upd_ready !== 1'b0 || hit !== 1'b0) begin
         errors++;
         $display("FAIL basic_write_cycle: ready=%b hit=%b required 0 0", upd_ready, hit);
      end
      wait_edge();               // array written at N+2
      model_write(10'h091, 4'hA, 16'h2000);
      checks++;
      if (upd_ready !== 1'b1 || busy !== 1'b0 || hit !== 1'b1 || predicted_target !== 16'h2000) begin
         errors++;
         $display("FAIL basic_after_write: ready=%b busy=%b hit=%b tgt=%h required 1 0 1 2000",
                  upd_ready, busy, hit, predicted_target);
      end
      fetch_pc = make_pc(10'h091, 4'hA, 1'b1, 1'b1);  // bit 15 and bit 0 ignored
      #1;
      checks++;
      if (hit !== 1'b1 || predicted_target !== 16'h2000) begin
         errors++;
         $display("FAIL basic_alias: hit=%b tgt=%h required 1 2000", hit, predicted_target);
      end
   endtask

   task automatic test_lru_replace();
      do_update(10'h001, 4'h3, 16'h1111);
      do_update(10'h002, 4'h3, 16'h2222);
      fetch_pc = make_pc(10'h001, 4'h3, 1'b0, 1'b0);
      lookup_valid = 1'b1;
      #1;
      checks++;
      if (hit !== 1'b1 || predicted_target !== 16'h1111) begin
         errors++;
         $display("FAIL lru_touch_lookup: hit=%b tgt=%h required 1 1111", hit, predicted_target);
      end
      wait_edge();
      model_touch(fetch_pc);
      lookup_valid = 1'b0;
      do_update(10'h003, 4'h3, 16'h3333);
      fetch_pc = make_pc(10'h001, 4'h3, 1'b0, 1'b0);
      #1;
      checks++;
      if (hit !== 1'b1 || predicted_target !== 16'h1111) begin
         errors++;
         $display("FAIL lru_keep_tag1: hit=%b tgt=%h required 1 1111", hit, predicted_target);
      end
      fetch_pc = make_pc(10'h002, 4'h3, 1'b0, 1'b0);
      #1;
      checks++;
      if (hit !== 1'b0 || predicted_target !== 16'h0000) begin
         errors++;
         $display("FAIL lru_evict_tag2: hit=%b tgt=%h required 0 0000", hit, predicted_target);
      end
      fetch_pc = make_pc(10'h003, 4'h3, 1'b0, 1'b0);
      #1;
      checks++;
      if (hit !== 1'b1 || predicted_target !== 16'h3333) begin
         errors++;
         $display("FAIL lru_new_tag3: hit=%b tgt=%h required 1 3333", hit, predicted_target);
      end
   endtask

   task automatic test_overwrite();
      do_update(10'h001, 4'h3, 16'h4444);
      fetch_pc = make_pc(10'h001, 4'h3, 1'b0, 1'b0);
      #1;
      checks++;
      if (hit !== 1'b1 || predicted_target !== 16'h4444) begin
         errors++;
         $display("FAIL overwrite_tag1: hit=%b tgt=%h required 1 4444", hit, predicted_target);
      end
      fetch_pc = make_pc(10'h003, 4'h3, 1'b0, 1'b0);
      #1;
      checks++;
      if (hit !== 1'b1 || predicted_target !== 16'h3333) begin
         errors++;
         $display("FAIL overwrite_other_way: hit=%b tgt=%h required 1 3333", hit, predicted_target);
      end
   endtask

   task automatic test_async_reset();
      upd_tag = 10'h005; upd_set = 4'h3; upd_target = 16'h5555; upd_valid = 1'b1;
      wait_edge();
      upd_valid = 1'b0;
      wait_edge();               // now in WRITE
      fetch_pc = make_pc(10'h001, 4'h3, 1'b0, 1'b0);
      #1;
      checks++;
      if (hit !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL areset_pre: hit=%b busy=%b required 1 1", hit, busy);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || hit !== 1'b0 || predicted_target !== 16'h0000 || upd_ready !== 1'b1) begin
         errors++;
         $display("FAIL areset_immediate: busy=%b hit=%b tgt=%h ready=%b required 0 0 0000 1",
                  busy, hit, predicted_target, upd_ready);
      end
      #13 rst_n = 1'b1;
      model_clear();
      wait_edge();
      for (int i = 1; i <= 5; i += 2) begin
         fetch_pc = make_pc(10'(i), 4'h3, 1'b0, 1'b0);
         #1;
         checks++;
         if (hit !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL areset_after tag=%0d: hit=%b busy=%b required 0 0", i, hit, busy);
         end
      end
   endtask

   task automatic test_flush();
      do_update(10'h007, 4'h5, 16'h7777);
      fetch_pc = make_pc(10'h007, 4'h5, 1'b0, 1'b0);
      // Flush while idle with an update offered: no transfer, entry cleared
      upd_tag = 10'h009; upd_set = 4'h5; upd_target = 16'h9999; upd_valid = 1'b1; flush = 1'b1;
      #1;
      checks++;
      if (upd_ready !== 1'b0 || hit !== 1'b1) begin
         errors++;
         $display("FAIL flush_idle_ready: ready=%b hit=%b required 0 1", upd_ready, hit);
      end
      wait_edge();
      upd_valid = 1'b0; flush = 1'b0;
      model_clear();
      #1;
      checks++;
      if (busy !== 1'b0 || hit !== 1'b0) begin
         errors++;
         $display("FAIL flush_idle_after: busy=%b hit=%b required 0 0", busy, hit);
      end
      // Flush in PROBE of an update to set 5
      upd_tag = 10'h008; upd_set = 4'h5; upd_target = 16'h8888; upd_valid = 1'b1;
      wait_edge();
      upd_valid = 1'b0; flush = 1'b1;
      wait_edge();
      flush = 1'b0;
      #1;
      checks++;
      if (upd_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL flush_probe_ready: ready=%b busy=%b required 1 0", upd_ready, busy);
      end
      wait_edge();
      wait_edge();
      fetch_pc = make_pc(10'h008, 4'h5, 1'b0, 1'b0);
      #1;
      checks++;
      if (hit !== 1'b0 || predicted_target !== 16'h0000) begin
         errors++;
         $display("FAIL flush_probe_nowrite: hit=%b tgt=%h required 0 0000", hit, predicted_target);
      end
   endtask

   task automatic test_back_to_back();
      upd_tag = 10'h155; upd_set = 4'hC; upd_target = 16'hBEEF; upd_valid = 1'b1;
      for (int i = 0; i < 9; i++) begin
         #1;
         checks++;
         if (upd_ready !== ((i % 3) == 0)) begin
            errors++;
            $display("FAIL b2b_ready cycle=%0d: ready=%b required %0d", i, upd_ready, (i % 3) == 0);
         end
         wait_edge();
      end
      upd_valid = 1'b0;          // drop while idle: no further transfer
      model_write(10'h155, 4'hC, 16'hBEEF);
      fetch_pc = make_pc(10'h155, 4'hC, 1'b0, 1'b0);
      wait_edge();
      checks++;
      if (busy !== 1'b0 || hit !== 1'b1 || predicted_target !== 16'hBEEF) begin
         errors++;
         $display("FAIL b2b_result: busy=%b hit=%b tgt=%h required 0 1 beef", busy, hit, predicted_target);
      end
   endtask

   task automatic test_random();
      bit eh; logic [15:0] et; int ew; int op;
      for (int it = 0; it < 400; it++) begin
         op = $urandom_range(0, 19);
         if (op < 12) begin
            fetch_pc = make_pc(10'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                               1'($urandom), 1'($urandom));
            lookup_valid = 1'($urandom);
            #1;
            model_lookup(fetch_pc, eh, et, ew);
            checks++;
            if (hit !== eh || predicted_target !== et) begin
               errors++;
               $display("FAIL rand_lookup pc=%h: hit=%b tgt=%h required hit=%b tgt=%h",
                        fetch_pc, hit, predicted_target, eh, et);
            end
            wait_edge();
            if (lookup_valid) model_touch(fetch_pc);
            lookup_valid = 1'b0;
         end else if (op < 19) begin
            do_update(10'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 16'($urandom));
         end else begin
            upd_valid = 1'($urandom); upd_tag = 10'h3AA; upd_set = 4'h2; flush = 1'b1;
            wait_edge();
            flush = 1'b0; upd_valid = 1'b0;
            model_clear();
            checks++;
            if (busy !== 1'b0) begin
               errors++;
               $display("FAIL rand_flush_transfer: busy=%b required 0", busy);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_update();
      test_lru_replace();
      test_overwrite();
      test_async_reset();
      test_flush();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule
